// File: rtl/pea_enable.sv
// Firing-rule checker for the PEA dataflow actor: registers whether the next
// firing of the current mode fits the FIFO token populations and free space.
module pea_enable #(
  parameter int word_size   = 16,
  parameter int buffer_size = 1024,
  localparam int CW = (buffer_size > 1) ? $clog2(buffer_size) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CW-1:0]        command_pop,
  input  logic [CW-1:0]        data_pop,
  input  logic [CW-1:0]        result_free_space,
  input  logic [CW-1:0]        status_free_space,
  input  logic [2:0]           mode,
  input  logic [word_size-1:0] command_in,
  output logic                 enable
);

  // Working width holds both a CW-bit count and the 5-bit N+1 without wrap.
  localparam int EW = ((CW > 5) ? CW : 5) + 1;

  typedef enum logic [2:0] {
    MODE_GET_COMMAND = 3'b000,
    MODE_STP         = 3'b001,
    MODE_EVP         = 3'b010,
    MODE_EVB         = 3'b011,
    MODE_OUTPUT      = 3'b100,
    MODE_RST         = 3'b101
  } mode_e;

  localparam logic [EW-1:0] ONE_X = EW'(1'b1);

  logic [3:0]    degree_s;
  logic [4:0]    block_s;
  logic [EW-1:0] command_pop_x_s;
  logic [EW-1:0] data_pop_x_s;
  logic [EW-1:0] result_free_x_s;
  logic [EW-1:0] status_free_x_s;
  logic [EW-1:0] coeff_need_s;
  logic [EW-1:0] block_need_s;
  logic          status_ok_s;
  logic          fire_s;
  logic          enable_r;
  logic          unused_cmd_bits_s;

  assign degree_s = command_in[9:6];
  assign block_s  = command_in[14:10];
  // Opcode, polynomial index and the reserved bit never influence the rule.
  assign unused_cmd_bits_s = ^{command_in[word_size-1:15], command_in[5:0]};

  assign command_pop_x_s = EW'(command_pop);
  assign data_pop_x_s    = EW'(data_pop);
  assign result_free_x_s = EW'(result_free_space);
  assign status_free_x_s = EW'(status_free_space);
  assign coeff_need_s    = EW'(degree_s) + ONE_X;
  assign block_need_s    = EW'(block_s);
  assign status_ok_s     = (status_free_x_s >= ONE_X);

  // Firing rule for the current mode; illegal modes never fire.
  always_comb begin
    fire_s = 1'b0;
    case (mode)
      MODE_GET_COMMAND: fire_s = (command_pop_x_s >= ONE_X);
      MODE_STP:         fire_s = (data_pop_x_s >= coeff_need_s) && status_ok_s;
      MODE_EVP:         fire_s = (data_pop_x_s >= ONE_X) &&
                                 (result_free_x_s >= ONE_X) && status_ok_s;
      MODE_EVB:         fire_s = (data_pop_x_s >= block_need_s) &&
                                 (result_free_x_s >= block_need_s) && status_ok_s;
      MODE_OUTPUT:      fire_s = status_ok_s;
      MODE_RST:         fire_s = status_ok_s;
      default:          fire_s = 1'b0;
    endcase
  end

  // Registered enable, cleared immediately by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enable_r <= 1'b0;
    end else begin
      enable_r <= fire_s;
    end
  end

  assign enable = enable_r;

endmodule

// File: tb/tb_pea_enable.sv
// Directed self-checking bench for pea_enable: reset, each mode's firing rule,
// count boundaries and asynchronous reset assertion.
module tb_pea_enable;

  localparam logic [2:0] M_GET = 3'b000;
  localparam logic [2:0] M_STP = 3'b001;
  localparam logic [2:0] M_EVP = 3'b010;
  localparam logic [2:0] M_EVB = 3'b011;
  localparam logic [2:0] M_OUT = 3'b100;
  localparam logic [2:0] M_RST = 3'b101;

  logic        clk;
  logic        rst;
  logic [9:0]  command_pop;
  logic [9:0]  data_pop;
  logic [9:0]  result_free_space;
  logic [9:0]  status_free_space;
  logic [2:0]  mode;
  logic [15:0] command_in;
  logic        enable;

  int n_assert;
  int n_fail;

  pea_enable #(.word_size(16), .buffer_size(1024)) dut (
    .clk               (clk),
    .rst               (rst),
    .command_pop       (command_pop),
    .data_pop          (data_pop),
    .result_free_space (result_free_space),
    .status_free_space (status_free_space),
    .mode              (mode),
    .command_in        (command_in),
    .enable            (enable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_in(input logic [2:0] m, input logic [15:0] cmd,
                        input logic [9:0] cp, input logic [9:0] dp,
                        input logic [9:0] rf, input logic [9:0] sf);
    mode = m;
    command_in = cmd;
    command_pop = cp;
    data_pop = dp;
    result_free_space = rf;
    status_free_space = sf;
  endtask

  task automatic check_now(input string tag, input logic exp);
    n_assert++;
    assert (enable === exp)
    else begin
      n_fail++;
      $error("FAIL %s: enable=%b expected %b", tag, enable, exp);
    end
  endtask

  // Apply inputs, let one edge pass, then sample 1 time unit later.
  task automatic step(input string tag, input logic exp);
    @(posedge clk);
    #1;
    check_now(tag, exp);
  endtask

  initial begin
    n_assert = 0;
    n_fail = 0;
    rst = 1'b1;
    set_in(M_GET, 16'h0000, 10'd5, 10'd5, 10'd5, 10'd5);
    #1;
    check_now("reset_t0", 1'b0);
    step("reset_hold1", 1'b0);
    step("reset_hold2", 1'b0);
    rst = 1'b0;
    #1;
    check_now("reset_release_pre_edge", 1'b0);
    step("reset_release", 1'b1);

    // GET_COMMAND
    set_in(M_GET, 16'h0000, 10'd0, 10'd0, 10'd0, 10'd0);
    step("get_empty", 1'b0);
    set_in(M_GET, 16'h0000, 10'd1, 10'd0, 10'd0, 10'd0);
    #1;
    check_now("get_one_latency", 1'b0);
    step("get_one", 1'b1);
    set_in(M_GET, 16'h0000, 10'd1023, 10'd0, 10'd0, 10'd0);
    step("get_max", 1'b1);

    // STP, N=3 with opcode/A/reserved bits set to show they are ignored
    set_in(M_STP, 16'h80FF, 10'd0, 10'd3, 10'd0, 10'd1);
    step("stp_n3_dp3", 1'b0);
    set_in(M_STP, 16'h80FF, 10'd0, 10'd4, 10'd0, 10'd0);
    step("stp_n3_nostatus", 1'b0);
    set_in(M_STP, 16'h80FF, 10'd0, 10'd4, 10'd0, 10'd1);
    step("stp_n3_ok", 1'b1);
    set_in(M_STP, 16'h03C0, 10'd0, 10'd16, 10'd0, 10'd1);
    step("stp_n15_dp16", 1'b1);
    set_in(M_STP, 16'h03C0, 10'd0, 10'd15, 10'd0, 10'd1);
    step("stp_n15_dp15", 1'b0);

    // EVP
    set_in(M_EVP, 16'h0000, 10'd0, 10'd1, 10'd0, 10'd1);
    step("evp_result_full", 1'b0);
    set_in(M_EVP, 16'h0000, 10'd0, 10'd1, 10'd1, 10'd1);
    step("evp_ok", 1'b1);
    set_in(M_EVP, 16'h0000, 10'd0, 10'd0, 10'd1, 10'd1);
    step("evp_data_empty", 1'b0);

    // EVB, b=31
    set_in(M_EVB, 16'h7C00, 10'd0, 10'd31, 10'd30, 10'd1);
    step("evb_b31_rf30", 1'b0);
    set_in(M_EVB, 16'h7C00, 10'd0, 10'd31, 10'd31, 10'd1);
    step("evb_b31_ok", 1'b1);
    set_in(M_EVB, 16'h7C00, 10'd0, 10'd30, 10'd100, 10'd1);
    step("evb_b31_dp30", 1'b0);
    set_in(M_EVB, 16'h0000, 10'd0, 10'd0, 10'd0, 10'd1);
    step("evb_b0_ok", 1'b1);
    set_in(M_EVB, 16'h0000, 10'd0, 10'd0, 10'd0, 10'd0);
    step("evb_b0_nostatus", 1'b0);

    // OUTPUT / RST / illegal
    set_in(M_OUT, 16'h0000, 10'd0, 10'd0, 10'd0, 10'd1);
    step("output_ok", 1'b1);
    set_in(M_OUT, 16'h0000, 10'd1023, 10'd1023, 10'd1023, 10'd0);
    step("output_full", 1'b0);
    set_in(M_RST, 16'h0000, 10'd0, 10'd0, 10'd0, 10'd1);
    step("rst_mode_ok", 1'b1);
    set_in(M_RST, 16'h0000, 10'd0, 10'd0, 10'd0, 10'd0);
    step("rst_mode_full", 1'b0);
    set_in(3'b110, 16'h0000, 10'd1023, 10'd1023, 10'd1023, 10'd1023);
    step("illegal_110", 1'b0);
    set_in(3'b111, 16'h0000, 10'd1023, 10'd1023, 10'd1023, 10'd1023);
    step("illegal_111", 1'b0);

    // Asynchronous reset between edges
    set_in(M_OUT, 16'h0000, 10'd0, 10'd0, 10'd0, 10'd1);
    step("pre_async_high", 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check_now("async_reset_drop", 1'b0);
    step("async_reset_hold", 1'b0);
    rst = 1'b0;
    step("async_reset_release", 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
